// File: rtl/pipeline_pkg.sv
// Shared definitions for the 16-bit pipeline: opcodes, default widths and
// the EX-stage multiplier state encoding.
package pipeline_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int OP_W_DEF   = 4;

    localparam int OP_NOP  = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_OR   = 4;
    localparam int OP_SLT  = 5;
    localparam int OP_ADDI = 6;
    localparam int OP_MUL  = 7;

    typedef enum logic {
        EX_IDLE = 1'b0,
        EX_BUSY = 1'b1
    } ex_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per cycle, DATA_W
// steps per operation, keeping only the low DATA_W product bits.
module seq_multiplier
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              abort,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    ex_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= EX_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        done     = 1'b0;
        case (state_q)
            EX_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = a;
                    mplier_d = b;
                    cnt_d    = '0;
                    state_d  = EX_BUSY;
                end
            end
            EX_BUSY: begin
                if (mplier_q[0])
                    acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = EX_IDLE;
                end
            end
            default: state_d = EX_IDLE;
        endcase
        // An abort kills the operation outright; no partial product escapes.
        if (abort) begin
            state_d = EX_IDLE;
            cnt_d   = '0;
            done    = 1'b0;
        end
    end

    // The final accumulation is exposed in the same cycle as done.
    assign product = acc_d;
    assign busy    = (state_q == EX_BUSY);

endmodule

// File: rtl/execute_stage.sv
// EX stage: single-cycle ALU ops register straight into EX/MEM; MUL runs on
// the sequential multiplier and holds ID/EX via stall_out until it completes.
module execute_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [OP_W-1:0]   opcode_in,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [31:0]       imm_in,
    output logic              stall_out,
    output logic              valid_out,
    output logic [OP_W-1:0]   opcode_out,
    output logic [DATA_W-1:0] result_out
);

    logic              valid_q, valid_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [DATA_W-1:0] alu_res;
    logic              alu_op;
    logic              mul_op;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    logic              unused_imm;

    assign unused_imm = ^imm_in[31:DATA_W];

    always_comb begin
        alu_res = '0;
        alu_op  = 1'b1;
        mul_op  = 1'b0;
        case (opcode_in)
            OP_W'(OP_ADD):  alu_res = operand_a + operand_b;
            OP_W'(OP_SUB):  alu_res = operand_a - operand_b;
            OP_W'(OP_AND):  alu_res = operand_a & operand_b;
            OP_W'(OP_OR):   alu_res = operand_a | operand_b;
            OP_W'(OP_SLT):  alu_res = {{(DATA_W-1){1'b0}},
                                       ($signed(operand_a) < $signed(operand_b))};
            OP_W'(OP_ADDI): alu_res = operand_a + imm_in[DATA_W-1:0];
            OP_W'(OP_MUL):  begin
                alu_op = 1'b0;
                mul_op = 1'b1;
            end
            default:        alu_op = 1'b0;
        endcase
    end

    always_comb begin
        valid_d   = 1'b0;
        opcode_d  = opcode_q;
        result_d  = result_q;
        mul_start = 1'b0;
        if (!flush) begin
            if (mul_busy) begin
                // Upstream inputs are held but ignored while the multiplier runs.
                if (mul_done) begin
                    valid_d  = 1'b1;
                    opcode_d = OP_W'(OP_MUL);
                    result_d = mul_product;
                end
            end else if (valid_in) begin
                if (alu_op) begin
                    valid_d  = 1'b1;
                    opcode_d = opcode_in;
                    result_d = alu_res;
                end else if (mul_op) begin
                    mul_start = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            result_q <= '0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
        end
    end

    seq_multiplier #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .abort   (flush),
        .start   (mul_start),
        .a       (operand_a),
        .b       (operand_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // busy is a register decode, so stall rises the cycle after MUL acceptance.
    assign stall_out  = mul_busy;
    assign valid_out  = valid_q;
    assign opcode_out = opcode_q;
    assign result_out = result_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized checks of execute_stage against a transaction-level
// model of the EX stage (expected results from plain integer arithmetic).
module tb_execute_stage;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        valid_in;
    logic [3:0]  opcode_in;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [31:0] imm_in;
    logic        stall_out;
    logic        valid_out;
    logic [3:0]  opcode_out;
    logic [15:0] result_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [15:0] last_res;
    logic [3:0]  last_op;
    int          nx_op;
    logic [15:0] nx_a, nx_b;
    logic [31:0] nx_imm;

    execute_stage dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .valid_in   (valid_in),
        .opcode_in  (opcode_in),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .imm_in     (imm_in),
        .stall_out  (stall_out),
        .valid_out  (valid_out),
        .opcode_out (opcode_out),
        .result_out (result_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint sx16(input logic [15:0] v);
        return v[15] ? longint'(v) - 65536 : longint'(v);
    endfunction

    function automatic logic [15:0] model(input int op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [31:0] imm);
        longint r;
        case (op)
            1:       r = longint'(a) + longint'(b);
            2:       r = longint'(a) - longint'(b);
            3:       r = longint'(a & b);
            4:       r = longint'(a | b);
            5:       r = (sx16(a) < sx16(b)) ? 1 : 0;
            6:       r = longint'(a) + longint'(imm[15:0]);
            7:       r = longint'(a) * longint'(b);
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    task automatic check_hold(input string tag);
        chk({tag, "_valid"},  32'(valid_out),  32'd0);
        chk({tag, "_result"}, 32'(result_out), 32'(last_res));
        chk({tag, "_opcode"}, 32'(opcode_out), 32'(last_op));
    endtask

    // Issues one instruction; for MUL the stall window drives nx_* as the held
    // upstream instruction, exactly as ID/EX would present it.
    task automatic do_instr(input int op, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] imm);
        logic [15:0] e;
        int          stalls;
        bit          bubble_ok;
        flush     = 1'b0;
        valid_in  = 1'b1;
        opcode_in = 4'(op);
        operand_a = a;
        operand_b = b;
        imm_in    = imm;
        step();
        e = model(op, a, b, imm);
        if (op >= 1 && op <= 6) begin
            last_res = e;
            last_op  = 4'(op);
            chk("alu_valid",  32'(valid_out),  32'd1);
            chk("alu_result", 32'(result_out), 32'(e));
            chk("alu_opcode", 32'(opcode_out), 32'(op));
            chk("alu_stall",  32'(stall_out),  32'd0);
        end else if (op == 7) begin
            stalls    = 0;
            bubble_ok = 1'b1;
            opcode_in = 4'(nx_op);
            operand_a = nx_a;
            operand_b = nx_b;
            imm_in    = nx_imm;
            while (stall_out === 1'b1 && stalls < 40) begin
                stalls++;
                if (valid_out !== 1'b0) bubble_ok = 1'b0;
                step();
            end
            last_res = e;
            last_op  = 4'd7;
            chk("mul_stall_cycles", 32'(stalls),     32'd16);
            chk("mul_bubble",       32'(bubble_ok),  32'd1);
            chk("mul_valid",        32'(valid_out),  32'd1);
            chk("mul_result",       32'(result_out), 32'(e));
            chk("mul_opcode",       32'(opcode_out), 32'd7);
        end else begin
            check_hold("nop");
        end
    endtask

    initial begin
        bit quiet;
        int cur_op;
        logic [15:0] cur_a, cur_b;
        logic [31:0] cur_imm;

        reset = 1'b1; flush = 1'b0; valid_in = 1'b0;
        opcode_in = '0; operand_a = '0; operand_b = '0; imm_in = '0;
        nx_op = 0; nx_a = '0; nx_b = '0; nx_imm = '0;
        last_res = '0; last_op = '0;
        step(); step();
        chk("rst_valid",  32'(valid_out),  32'd0);
        chk("rst_result", 32'(result_out), 32'd0);
        chk("rst_opcode", 32'(opcode_out), 32'd0);
        chk("rst_stall",  32'(stall_out),  32'd0);
        reset = 1'b0;

        // Back-to-back single-cycle ops and boundary values.
        do_instr(1, 16'd3, 16'd4, 32'd0);
        chk("add_3_4", 32'(result_out), 32'h0007);
        do_instr(2, 16'd2, 16'd5, 32'd0);
        chk("sub_2_5", 32'(result_out), 32'hFFFD);
        do_instr(5, 16'hFFFF, 16'd1, 32'd0);
        chk("slt_neg", 32'(result_out), 32'h0001);
        do_instr(5, 16'd1, 16'hFFFF, 32'd0);
        chk("slt_pos", 32'(result_out), 32'h0000);
        do_instr(6, 16'd10, 16'd0, 32'hFFFF_FFFE);
        chk("addi_neg", 32'(result_out), 32'h0008);
        do_instr(9, 16'd1, 16'd1, 32'd0);

        // MUL with the following ADD held upstream during the stall.
        nx_op = 1; nx_a = 16'd1; nx_b = 16'd1; nx_imm = '0;
        do_instr(7, 16'd300, 16'd300, 32'd0);
        chk("mul_300", 32'(result_out), 32'h5F90);
        do_instr(1, 16'd1, 16'd1, 32'd0);
        chk("held_add", 32'(result_out), 32'h0002);

        // Reset in the 5th MUL cycle.
        valid_in = 1'b1; opcode_in = 4'd7; operand_a = 16'd1234; operand_b = 16'd77;
        step();
        valid_in = 1'b0;
        step(); step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        last_res = '0; last_op = '0;
        chk("rstmul_valid",  32'(valid_out),  32'd0);
        chk("rstmul_result", 32'(result_out), 32'd0);
        chk("rstmul_opcode", 32'(opcode_out), 32'd0);
        chk("rstmul_stall",  32'(stall_out),  32'd0);
        do_instr(1, 16'd1, 16'd2, 32'd0);
        chk("post_rst_add", 32'(result_out), 32'h0003);

        // flush against an incoming ADD, then flush mid-MUL.
        flush = 1'b1; valid_in = 1'b1; opcode_in = 4'd1; operand_a = 16'd9; operand_b = 16'd9;
        step();
        check_hold("flush_add");
        chk("flush_add_stall", 32'(stall_out), 32'd0);
        flush = 1'b0; valid_in = 1'b1; opcode_in = 4'd7; operand_a = 16'd50; operand_b = 16'd60;
        step();
        chk("pre_flush_stall", 32'(stall_out), 32'd1);
        valid_in = 1'b0;
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_hold("flush_mul");
        chk("flush_mul_stall", 32'(stall_out), 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid_out !== 1'b0 || stall_out !== 1'b0) quiet = 1'b0;
        end
        chk("flush_mul_quiet", 32'(quiet), 32'd1);
        chk("flush_mul_hold", 32'(result_out), 32'(last_res));

        // Idle cycles after ADD 5+5.
        do_instr(1, 16'd5, 16'd5, 32'd0);
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_hold("idle");
        end
        chk("idle_0a", 32'(result_out), 32'h000A);

        // Back-to-back MULs with no bubble between them.
        nx_op = 7; nx_a = 16'hFFFF; nx_b = 16'hFFFF; nx_imm = '0;
        do_instr(7, 16'd7, 16'd9, 32'd0);
        nx_op = 0; nx_a = '0; nx_b = '0;
        do_instr(7, 16'hFFFF, 16'hFFFF, 32'd0);
        chk("mul_ffff", 32'(result_out), 32'h0001);

        // Randomized instruction stream.
        cur_op  = int'($urandom_range(0, 15));
        cur_a   = 16'($urandom);
        cur_b   = 16'($urandom);
        cur_imm = $urandom;
        for (int n = 0; n < 60; n++) begin
            nx_op  = int'($urandom_range(0, 15));
            nx_a   = 16'($urandom);
            nx_b   = 16'($urandom);
            nx_imm = $urandom;
            do_instr(cur_op, cur_a, cur_b, cur_imm);
            cur_op = nx_op; cur_a = nx_a; cur_b = nx_b; cur_imm = nx_imm;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
